// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential multiply-accumulate family.
package mul_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CALC   = 2'd1,
      FINISH = 2'd2
   } state_e;

   // Limits are computed wide enough for operands up to MAX_WIDTH bits.
   localparam int unsigned MAX_WIDTH = 64;
   localparam int unsigned LIM_W     = 2 * MAX_WIDTH + 2;

   function automatic int unsigned hs_latency(input int unsigned w);
      return w + 2;
   endfunction

   function automatic logic signed [LIM_W-1:0] lim_smax(input int unsigned w);
      logic signed [LIM_W-1:0] one;
      one = LIM_W'(1);
      return (one <<< (w - 1)) - one;
   endfunction

   function automatic logic signed [LIM_W-1:0] lim_smin(input int unsigned w);
      logic signed [LIM_W-1:0] one;
      one = LIM_W'(1);
      return -(one <<< (w - 1));
   endfunction

   function automatic logic signed [LIM_W-1:0] lim_umax(input int unsigned w);
      logic signed [LIM_W-1:0] one;
      one = LIM_W'(1);
      return (one <<< w) - one;
   endfunction

endpackage

// File: rtl/mul_round_sat.sv
// Fixed-point rounding, optional accumulation, range check and clamp of a signed product.
module mul_round_sat
   import mul_pkg::*;
#(
   parameter int unsigned  C_WIDTH     = 32,
   parameter int unsigned  FIXED_POINT = 0,
   parameter bit           SATURATE    = 1'b1,
   localparam int unsigned AW          = 2 * C_WIDTH + 2
) (
   input  logic signed [AW-1:0]      prod_i,
   input  logic signed [AW-1:0]      acc_i,
   input  logic                      signed_i,
   input  logic                      acc_en_i,
   output logic signed [AW-1:0]      acc_c,
   output logic        [C_WIDTH-1:0] y_c,
   output logic                      overflow_c
);

   localparam logic signed [AW-1:0]  S_MAX  = AW'(lim_smax(C_WIDTH));
   localparam logic signed [AW-1:0]  S_MIN  = AW'(lim_smin(C_WIDTH));
   localparam logic signed [AW-1:0]  U_MAX  = AW'(lim_umax(C_WIDTH));
   localparam logic [C_WIDTH-1:0]    Y_SMAX = C_WIDTH'(S_MAX);
   localparam logic [C_WIDTH-1:0]    Y_SMIN = C_WIDTH'(S_MIN);
   localparam logic [C_WIDTH-1:0]    Y_UMAX = C_WIDTH'(U_MAX);

   logic signed [AW-1:0] scaled;
   logic signed [AW-1:0] sum;
   logic                 hi;
   logic                 lo;

   // Round half up: add half an LSB of the result, then floor via arithmetic shift.
   generate
      if (FIXED_POINT > 0) begin : g_round
         localparam logic signed [AW-1:0] HALF = AW'(1) <<< (FIXED_POINT - 1);
         assign scaled = (prod_i + HALF) >>> FIXED_POINT;
      end else begin : g_noround
         assign scaled = prod_i;
      end
   endgenerate

   always_comb begin
      sum        = scaled;
      acc_c      = acc_i;
      hi         = 1'b0;
      lo         = 1'b0;
      y_c        = sum[C_WIDTH-1:0];
      overflow_c = 1'b0;

      if (acc_en_i) begin
         sum   = acc_i + scaled;
         acc_c = sum;
      end

      if (signed_i) begin
         hi = sum > S_MAX;
         lo = sum < S_MIN;
      end else begin
         hi = sum > U_MAX;
         lo = sum[AW-1];
      end
      overflow_c = hi | lo;

      if (overflow_c && (SATURATE == 1'b1)) begin
         if (signed_i) begin
            y_c = lo ? Y_SMIN : Y_SMAX;
         end else begin
            y_c = lo ? '0 : Y_UMAX;
         end
      end else begin
         y_c = sum[C_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/mul_acc_seq.sv
// Radix-2 shift-add multiplier with fixed-point scaling, saturation and running accumulator.
module mul_acc_seq
   import mul_pkg::*;
#(
   parameter int unsigned C_WIDTH     = 32,
   parameter int unsigned FIXED_POINT = 0,
   parameter bit          SATURATE    = 1'b1
) (
   input  logic               ctl_clk,
   input  logic               reset,
   input  logic [C_WIDTH-1:0] a,
   input  logic [C_WIDTH-1:0] b,
   input  logic               signed_cal,
   input  logic               acc_en,
   input  logic               acc_clr,
   input  logic               trigger,
   output logic               ready,
   output logic               done,
   output logic [C_WIDTH-1:0] y,
   output logic               overflow
);

   localparam int unsigned AW = 2 * C_WIDTH + 2;
   localparam int unsigned PW = 2 * C_WIDTH;
   localparam int unsigned CW = $clog2(C_WIDTH + 1);

   state_e                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [PW-1:0]         mcand_q, mcand_d;
   logic [C_WIDTH-1:0]    mplier_q, mplier_d;
   logic [PW-1:0]         prod_q, prod_d;
   logic                  neg_q, neg_d;
   logic                  sgn_q, sgn_d;
   logic                  acc_en_q, acc_en_d;
   logic signed [AW-1:0]  acc_q, acc_d;
   logic [C_WIDTH-1:0]    y_q, y_d;
   logic                  overflow_q, overflow_d;
   logic                  done_q, done_d;
   logic                  ready_q, ready_d;

   logic [C_WIDTH:0]      a_ext, b_ext;
   logic [C_WIDTH-1:0]    a_mag, b_mag;
   logic signed [AW-1:0]  prod_ext, sprod;
   logic signed [AW-1:0]  acc_fin;
   logic [C_WIDTH-1:0]    y_fin;
   logic                  ovf_fin;

   assign ready    = ready_q;
   assign done     = done_q;
   assign y        = y_q;
   assign overflow = overflow_q;

   // Magnitudes are formed in C_WIDTH+1 bits so the most-negative operand stays exact.
   always_comb begin
      a_ext = {signed_cal & a[C_WIDTH-1], a};
      b_ext = {signed_cal & b[C_WIDTH-1], b};
      a_mag = a_ext[C_WIDTH] ? C_WIDTH'(-a_ext) : a;
      b_mag = b_ext[C_WIDTH] ? C_WIDTH'(-b_ext) : b;
   end

   always_comb begin
      prod_ext = AW'(prod_q);
      sprod    = neg_q ? -prod_ext : prod_ext;
   end

   mul_round_sat #(
      .C_WIDTH     (C_WIDTH),
      .FIXED_POINT (FIXED_POINT),
      .SATURATE    (SATURATE)
   ) u_round_sat (
      .prod_i     (sprod),
      .acc_i      (acc_q),
      .signed_i   (sgn_q),
      .acc_en_i   (acc_en_q),
      .acc_c      (acc_fin),
      .y_c        (y_fin),
      .overflow_c (ovf_fin)
   );

   always_ff @(posedge ctl_clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         mcand_q    <= '0;
         mplier_q   <= '0;
         prod_q     <= '0;
         neg_q      <= 1'b0;
         sgn_q      <= 1'b0;
         acc_en_q   <= 1'b0;
         acc_q      <= '0;
         y_q        <= '0;
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
         ready_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mcand_q    <= mcand_d;
         mplier_q   <= mplier_d;
         prod_q     <= prod_d;
         neg_q      <= neg_d;
         sgn_q      <= sgn_d;
         acc_en_q   <= acc_en_d;
         acc_q      <= acc_d;
         y_q        <= y_d;
         overflow_q <= overflow_d;
         done_q     <= done_d;
         ready_q    <= ready_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      prod_d     = prod_q;
      neg_d      = neg_q;
      sgn_d      = sgn_q;
      acc_en_d   = acc_en_q;
      acc_d      = acc_q;
      y_d        = y_q;
      overflow_d = overflow_q;
      done_d     = 1'b0;
      ready_d    = ready_q;

      unique case (state_q)
         IDLE: begin
            // Clear lands before any new product, so clear+trigger accumulates onto zero.
            if (acc_clr) begin
               acc_d = '0;
            end
            if (trigger) begin
               mcand_d  = PW'(a_mag);
               mplier_d = b_mag;
               prod_d   = '0;
               neg_d    = signed_cal & (a[C_WIDTH-1] ^ b[C_WIDTH-1]);
               sgn_d    = signed_cal;
               acc_en_d = acc_en;
               cnt_d    = CW'(C_WIDTH);
               ready_d  = 1'b0;
               state_d  = CALC;
            end
         end
         CALC: begin
            if (mplier_q[0]) begin
               prod_d = prod_q + mcand_q;
            end
            mplier_d = mplier_q >> 1;
            mcand_d  = mcand_q << 1;
            cnt_d    = cnt_q - CW'(1);
            if (cnt_d == '0) begin
               state_d = FINISH;
            end
         end
         FINISH: begin
            acc_d      = acc_fin;
            y_d        = y_fin;
            overflow_d = ovf_fin;
            done_d     = 1'b1;
            ready_d    = 1'b1;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule
